// File: rtl/iob_acc_mc_pkg.sv
// Shared constants and helpers for the multi-channel accumulator.
package iob_acc_mc_pkg;

  localparam int unsigned IOB_ACC_MC_WRAP = 0;
  localparam int unsigned IOB_ACC_MC_SAT  = 1;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned ch_width(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/iob_acc_mc_add.sv
// Shared sign-extend/add/clamp datapath; flags any out-of-range result.
module iob_acc_mc_add
  import iob_acc_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned INCR_W = 8,
  parameter int unsigned SAT    = IOB_ACC_MC_WRAP
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [INCR_W-1:0] incr_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              ovf_o
);

  // Two guard bits hold every acc+incr result as a signed value.
  logic [DATA_W+1:0] sum;
  logic              over;
  logic              under;

  always_comb begin
    sum   = {2'b00, acc_i} + {{(DATA_W + 2 - INCR_W){incr_i[INCR_W-1]}}, incr_i};
    under = sum[DATA_W+1];
    over  = ~sum[DATA_W+1] & sum[DATA_W];
    ovf_o = over | under;
    sum_o = sum[DATA_W-1:0];
    if (SAT == IOB_ACC_MC_SAT) begin
      if (over) begin
        sum_o = '1;
      end else if (under) begin
        sum_o = '0;
      end
    end
  end

endmodule

// File: rtl/iob_reg_re.sv
// Register with async reset, clock enable, sync clear and load enable.
module iob_reg_re #(
  parameter int unsigned        DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q <= RST_VAL;
    end else if (cke_i) begin
      if (rst_i) begin
        data_q <= RST_VAL;
      end else if (en_i) begin
        data_q <= data_i;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/iob_acc_mc.sv
// N_CH independent loadable accumulators sharing one command port and one adder.
module iob_acc_mc
  import iob_acc_mc_pkg::*;
#(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       INCR_W  = 8,
  parameter int unsigned       N_CH    = 4,
  parameter int unsigned       SAT     = IOB_ACC_MC_WRAP,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
  localparam int unsigned      CH_W    = ch_width(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   cke_i,
  input  logic                   arst_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [CH_W-1:0]        ch_i,
  input  logic                   ld_i,
  input  logic [DATA_W-1:0]      ld_val_i,
  input  logic [INCR_W-1:0]      incr_i,
  input  logic [N_CH-1:0]        clr_ovf_i,
  output logic [N_CH*DATA_W-1:0] data_o,
  output logic [N_CH-1:0]        ovf_o,
  output logic                   res_valid_o,
  output logic [DATA_W-1:0]      res_o
);

  // Pad the channel array to a power of two so any ch_i indexes safely.
  localparam int unsigned N_SLOT = 1 << CH_W;

  logic [DATA_W-1:0] acc [N_SLOT];
  logic [N_CH-1:0]   sel;
  logic [N_CH-1:0]   ovf_d;
  logic [DATA_W-1:0] add_sum;
  logic [DATA_W-1:0] wr_val;
  logic              add_ovf;
  logic              cmd_ok;

  // cke_i and rst_i gating happens inside the registers.
  assign cmd_ok = en_i & valid_i & (32'(ch_i) < N_CH);
  assign wr_val = ld_i ? ld_val_i : add_sum;

  iob_acc_mc_add #(
    .DATA_W (DATA_W),
    .INCR_W (INCR_W),
    .SAT    (SAT)
  ) u_add (
    .acc_i  (acc[ch_i]),
    .incr_i (incr_i),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  for (genvar k = 0; k < N_SLOT; k++) begin : g_slot
    if (k < N_CH) begin : g_ch
      assign sel[k]   = cmd_ok & (ch_i == CH_W'(k));
      // A same-cycle overflow outranks the clear.
      assign ovf_d[k] = (ovf_o[k] & ~clr_ovf_i[k]) | (sel[k] & ~ld_i & add_ovf);
      assign data_o[k*DATA_W +: DATA_W] = acc[k];

      iob_reg_re #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
      ) u_acc_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .rst_i  (rst_i),
        .en_i   (sel[k]),
        .data_i (wr_val),
        .data_o (acc[k])
      );
    end else begin : g_pad
      assign acc[k] = '0;
    end
  end

  iob_reg_re #(
    .DATA_W  (N_CH),
    .RST_VAL ('0)
  ) u_ovf_reg (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .arst_i (arst_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .data_i (ovf_d),
    .data_o (ovf_o)
  );

  iob_reg_re #(
    .DATA_W  (DATA_W),
    .RST_VAL ('0)
  ) u_res_reg (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .arst_i (arst_i),
    .rst_i  (rst_i),
    .en_i   (cmd_ok),
    .data_i (wr_val),
    .data_o (res_o)
  );

  iob_reg_re #(
    .DATA_W  (1),
    .RST_VAL (1'b0)
  ) u_res_valid_reg (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .arst_i (arst_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .data_i (cmd_ok),
    .data_o (res_valid_o)
  );

endmodule

// File: tb/tb_iob_acc_mc.sv
// Bench for iob_acc_mc: a wrap/4-channel instance and a saturate/3-channel/RST_VAL=0x10 instance.
module tb_iob_acc_mc;

  logic       clk = 1'b0;
  logic       cke, arst, rst, en, valid, ld;
  logic [1:0] ch;
  logic [7:0] ld_val;
  logic [3:0] incr, clr_ovf;

  logic [31:0] data_a;
  logic [3:0]  ovf_a;
  logic        vld_a;
  logic [7:0]  res_a;
  logic [23:0] data_b;
  logic [2:0]  ovf_b;
  logic        vld_b;
  logic [7:0]  res_b;

  always #5 clk = ~clk;

  iob_acc_mc #(
    .DATA_W (8), .INCR_W (4), .N_CH (4), .SAT (0), .RST_VAL (8'h00)
  ) dut_a (
    .clk_i (clk), .cke_i (cke), .arst_i (arst), .rst_i (rst), .en_i (en),
    .valid_i (valid), .ch_i (ch), .ld_i (ld), .ld_val_i (ld_val), .incr_i (incr),
    .clr_ovf_i (clr_ovf), .data_o (data_a), .ovf_o (ovf_a), .res_valid_o (vld_a),
    .res_o (res_a)
  );

  iob_acc_mc #(
    .DATA_W (8), .INCR_W (4), .N_CH (3), .SAT (1), .RST_VAL (8'h10)
  ) dut_b (
    .clk_i (clk), .cke_i (cke), .arst_i (arst), .rst_i (rst), .en_i (en),
    .valid_i (valid), .ch_i (ch), .ld_i (ld), .ld_val_i (ld_val), .incr_i (incr),
    .clr_ovf_i (clr_ovf[2:0]), .data_o (data_b), .ovf_o (ovf_b), .res_valid_o (vld_b),
    .res_o (res_b)
  );

  // Reference state.
  logic [7:0] ma [4];
  logic [7:0] mb [3];
  logic [3:0] mova;
  logic [2:0] movb;
  logic       mvla, mvlb;
  logic [7:0] mra, mrb;
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [1:0] ch;
    logic       ld;
    logic [7:0] val;
    logic [3:0] incr;
    logic [7:0] res_a;
    logic [3:0] ovf_a;
    logic       vld_b;
    logic [7:0] res_b;
    logic [2:0] ovf_b;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) ma[k] = 8'h00;
    for (int k = 0; k < 3; k++) mb[k] = 8'h10;
    mova = '0; movb = '0; mvla = 1'b0; mvlb = 1'b0; mra = '0; mrb = '0;
    qa.delete(); qb.delete();
  endtask

  task automatic model_step();
    int s;
    logic acc_a, acc_b;
    if (!cke) return;
    if (rst) begin
      model_reset();
      return;
    end
    mova = mova & ~clr_ovf;
    movb = movb & ~clr_ovf[2:0];
    acc_a = en && valid;
    acc_b = en && valid && (ch < 2'd3);
    if (acc_a) begin
      s = int'(ma[ch]) + int'($signed(incr));
      if (ld) ma[ch] = ld_val;
      else begin
        if (s > 255 || s < 0) mova[ch] = 1'b1;
        ma[ch] = s[7:0];
      end
      qa.push_back(ma[ch]);
      mra = ma[ch];
    end
    if (acc_b) begin
      s = int'(mb[ch]) + int'($signed(incr));
      if (ld) mb[ch] = ld_val;
      else if (s > 255) begin movb[ch] = 1'b1; mb[ch] = 8'hFF; end
      else if (s < 0) begin movb[ch] = 1'b1; mb[ch] = 8'h00; end
      else mb[ch] = s[7:0];
      qb.push_back(mb[ch]);
      mrb = mb[ch];
    end
    mvla = acc_a;
    mvlb = acc_b;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " vld_a"}, vld_a, mvla);
    chk({tag, " vld_b"}, vld_b, mvlb);
    if (qa.size() > 0) chk({tag, " sb_res_a"}, res_a, qa.pop_front());
    if (qb.size() > 0) chk({tag, " sb_res_b"}, res_b, qb.pop_front());
    chk({tag, " res_a"}, res_a, mra);
    chk({tag, " res_b"}, res_b, mrb);
    chk({tag, " ovf_a"}, ovf_a, mova);
    chk({tag, " ovf_b"}, ovf_b, movb);
    for (int k = 0; k < 4; k++) chk({tag, " data_a"}, data_a[k*8 +: 8], ma[k]);
    for (int k = 0; k < 3; k++) chk({tag, " data_b"}, data_b[k*8 +: 8], mb[k]);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_state(tag);
    valid = 1'b0;
    clr_ovf = '0;
  endtask

  task automatic cmd(input string tag, input logic [1:0] c, input logic l, input logic [7:0] v,
                     input logic [3:0] i, input logic [3:0] clr);
    valid = 1'b1; ch = c; ld = l; ld_val = v; incr = i; clr_ovf = clr;
    tick(tag);
  endtask

  // Asserted and released between clock edges; outputs must clear without an edge.
  task automatic do_arst(input string tag);
    #1 arst = 1'b1;
    #1;
    model_reset();
    chk({tag, " arst data_a"}, data_a, 32'h0);
    chk({tag, " arst data_b"}, data_b, 32'h101010);
    chk({tag, " arst ovf_a"}, ovf_a, 0);
    chk({tag, " arst ovf_b"}, ovf_b, 0);
    chk({tag, " arst vld_a"}, vld_a, 0);
    chk({tag, " arst vld_b"}, vld_b, 0);
    chk({tag, " arst res_a"}, res_a, 0);
    #1 arst = 1'b0;
  endtask

  initial begin
    cke = 1'b1; arst = 1'b0; rst = 1'b0; en = 1'b1; valid = 1'b0; ld = 1'b0;
    ch = '0; ld_val = '0; incr = '0; clr_ovf = '0;

    // ch, ld, val, incr, res_a, ovf_a, vld_b, res_b, ovf_b
    vecs[0] = '{2'd2, 1'b1, 8'hFE, 4'h0, 8'hFE, 4'b0000, 1'b1, 8'hFE, 3'b000};
    vecs[1] = '{2'd2, 1'b0, 8'h00, 4'h3, 8'h01, 4'b0100, 1'b1, 8'hFF, 3'b100};
    vecs[2] = '{2'd0, 1'b0, 8'h00, 4'hE, 8'hFE, 4'b0101, 1'b1, 8'h0E, 3'b100};
    vecs[3] = '{2'd1, 1'b1, 8'hFC, 4'h0, 8'hFC, 4'b0101, 1'b1, 8'hFC, 3'b100};
    vecs[4] = '{2'd1, 1'b0, 8'h00, 4'h7, 8'h03, 4'b0111, 1'b1, 8'hFF, 3'b110};
    vecs[5] = '{2'd3, 1'b1, 8'h03, 4'h0, 8'h03, 4'b0111, 1'b0, 8'hFF, 3'b110};
    vecs[6] = '{2'd3, 1'b0, 8'h00, 4'h8, 8'hFB, 4'b1111, 1'b0, 8'hFF, 3'b110};
    vecs[7] = '{2'd0, 1'b1, 8'h03, 4'h0, 8'h03, 4'b1111, 1'b1, 8'h03, 3'b110};
    vecs[8] = '{2'd0, 1'b0, 8'h00, 4'h8, 8'hFB, 4'b1111, 1'b1, 8'h00, 3'b111};

    do_arst("init");

    foreach (vecs[i]) begin
      cmd($sformatf("vec%0d", i), vecs[i].ch, vecs[i].ld, vecs[i].val, vecs[i].incr, 4'b0);
      chk($sformatf("vec%0d vld_a", i), vld_a, 1'b1);
      chk($sformatf("vec%0d res_a", i), res_a, vecs[i].res_a);
      chk($sformatf("vec%0d ovf_a", i), ovf_a, vecs[i].ovf_a);
      chk($sformatf("vec%0d vld_b", i), vld_b, vecs[i].vld_b);
      chk($sformatf("vec%0d res_b", i), res_b, vecs[i].res_b);
      chk($sformatf("vec%0d ovf_b", i), ovf_b, vecs[i].ovf_b);
    end
    tick("idle");
    chk("idle vld_a", vld_a, 1'b0);

    // Back-to-back increments on one channel chain through the register.
    do_arst("b2b");
    for (int i = 0; i < 5; i++) begin
      cmd("b2b", 2'd0, 1'b0, 8'h00, 4'h1, 4'b0);
      chk("b2b res_a", res_a, 8'(i + 1));
      chk("b2b res_b", res_b, 8'(8'h11 + i));
      chk("b2b vld_a", vld_a, 1'b1);
    end
    chk("b2b other_a", data_a[31:8], 24'h0);

    // Overflow and clear on the same channel in the same cycle.
    cmd("ld_ff", 2'd1, 1'b1, 8'hFF, 4'h0, 4'b0);
    cmd("set_clr", 2'd1, 1'b0, 8'h00, 4'h1, 4'b0010);
    chk("set_wins_a", ovf_a[1], 1'b1);
    chk("set_wins_b", ovf_b[1], 1'b1);

    // Clock enable low freezes everything, including the result strobe.
    cke = 1'b0;
    cmd("cke0", 2'd2, 1'b1, 8'h55, 4'h0, 4'b1111);
    chk("cke0 data_a2", data_a[23:16], 8'h00);
    chk("cke0 vld_hold", vld_a, 1'b1);
    chk("cke0 ovf_hold", ovf_a, 4'b0010);
    cke = 1'b1;

    // Global enable low drops commands but still clears flags.
    en = 1'b0;
    cmd("en0", 2'd0, 1'b1, 8'h99, 4'h0, 4'b1111);
    chk("en0 ovf_a", ovf_a, 4'b0000);
    chk("en0 vld_a", vld_a, 1'b0);
    chk("en0 data_a0", data_a[7:0], 8'h05);
    en = 1'b1;

    // Sync clear beats a simultaneous command.
    rst = 1'b1;
    cmd("rst", 2'd0, 1'b1, 8'h77, 4'h0, 4'b0);
    rst = 1'b0;
    chk("rst data_b", data_b, 24'h101010);
    chk("rst res_a", res_a, 8'h00);
    chk("rst vld_b", vld_b, 1'b0);

    // Async reset mid-stream, then the next command is taken normally.
    cmd("pre_arst", 2'd0, 1'b0, 8'h00, 4'h1, 4'b0);
    do_arst("mid");
    cmd("post_arst", 2'd0, 1'b1, 8'h42, 4'h0, 4'b0);
    chk("post_arst res_a", res_a, 8'h42);
    chk("post_arst vld_a", vld_a, 1'b1);
    tick("tail");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
